// File: rtl/io_handshake_responder.sv
// Board-side responder for the CPU IN/OUT/HALT stall protocol: debounced release
// keys, a latch for IN data from the switches, and an OUT capture for the displays.

module io_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_key,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pressed_raw;
  logic          sync_a;
  logic          sync_b;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] count;

  assign pressed_raw = ACTIVE_LOW ? ~raw_key : raw_key;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= pressed_raw;
      sync_b <= sync_a;
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      level_q <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level_q;
      if (sync_b == level_q) begin
        count <= '0;
      end else if (count == COUNT_LAST) begin
        level_q <= ~level_q;
        count   <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_d;

endmodule

module io_handshake_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inPending,
  input  logic                  haltPending,
  input  logic                  outWrite,
  input  logic [DATA_WIDTH-1:0] outData,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  confirmKey,
  input  logic                  resumeKey,
  output logic                  inFlag,
  output logic                  resumeFlag,
  output logic [DATA_WIDTH-1:0] inData,
  output logic [DATA_WIDTH-1:0] outValue,
  output logic [7:0]            outCount,
  output logic                  waiting
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IN,
    WAIT_HALT,
    RELEASE
  } state_t;

  state_t state;
  state_t state_next;

  logic confirm_level;
  logic confirm_press;
  logic resume_level;
  logic resume_press;
  logic in_flag_c;
  logic resume_flag_c;
  logic capture_in;

  io_key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (KEY_ACTIVE_LOW != 0)
  ) u_confirm_db (
    .clock   (clock),
    .reset   (reset),
    .raw_key (confirmKey),
    .level   (confirm_level),
    .press   (confirm_press)
  );

  io_key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (KEY_ACTIVE_LOW != 0)
  ) u_resume_db (
    .clock   (clock),
    .reset   (reset),
    .raw_key (resumeKey),
    .level   (resume_level),
    .press   (resume_press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      waiting <= 1'b0;
    end else begin
      state   <= state_next;
      waiting <= (state_next == WAIT_IN) || (state_next == WAIT_HALT);
    end
  end

  // RELEASE waits for both keys to let go so one held press cannot serve two instructions.
  always_comb begin
    state_next    = state;
    in_flag_c     = 1'b0;
    resume_flag_c = 1'b0;
    capture_in    = 1'b0;
    case (state)
      IDLE: begin
        if (inPending) begin
          state_next = WAIT_IN;
        end else if (haltPending) begin
          state_next = WAIT_HALT;
        end
      end
      WAIT_IN: begin
        if (confirm_press) begin
          in_flag_c  = 1'b1;
          capture_in = 1'b1;
          state_next = RELEASE;
        end else if (!inPending) begin
          state_next = IDLE;
        end
      end
      WAIT_HALT: begin
        if (resume_press) begin
          resume_flag_c = 1'b1;
          state_next    = RELEASE;
        end else if (!haltPending) begin
          state_next = IDLE;
        end
      end
      RELEASE: begin
        if (!confirm_level && !resume_level) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign inFlag     = in_flag_c;
  assign resumeFlag = resume_flag_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      inData <= '0;
    end else if (capture_in) begin
      inData <= DATA_WIDTH'(switches);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outValue <= '0;
      outCount <= '0;
    end else if (outWrite) begin
      outValue <= outData;
      outCount <= outCount + 8'd1;
    end
  end

  assert property (@(posedge clock) disable iff (reset) !(inFlag && resumeFlag));
  assert property (@(posedge clock) disable iff (reset) inFlag |=> !inFlag);
  assert property (@(posedge clock) disable iff (reset) resumeFlag |=> !resumeFlag);

endmodule

// File: tb/tb_io_handshake_responder.sv
// Scoreboard bench for io_handshake_responder: directed scenarios plus random
// key/pending traffic checked against an event-level reference model.

module tb_io_handshake_responder;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          inPending;
  logic          haltPending;
  logic          outWrite;
  logic [DW-1:0] outData;
  logic [SW-1:0] switches;
  logic          confirmKey;
  logic          resumeKey;
  logic          inFlag;
  logic          resumeFlag;
  logic [DW-1:0] inData;
  logic [DW-1:0] outValue;
  logic [7:0]    outCount;
  logic          waiting;

  always #5 clock = ~clock;

  io_handshake_responder #(
    .DATA_WIDTH      (DW),
    .SW_WIDTH        (SW),
    .DEBOUNCE_CYCLES (DB),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .inPending   (inPending),
    .haltPending (haltPending),
    .outWrite    (outWrite),
    .outData     (outData),
    .switches    (switches),
    .confirmKey  (confirmKey),
    .resumeKey   (resumeKey),
    .inFlag      (inFlag),
    .resumeFlag  (resumeFlag),
    .inData      (inData),
    .outValue    (outValue),
    .outCount    (outCount),
    .waiting     (waiting)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input bit ip, input bit hp, input bit ck, input bit rk);
    inPending   = ip;
    haltPending = hp;
    confirmKey  = ck;
    resumeKey   = rk;
  endtask

  // Reference model: keys become "pressed" after DB consecutive disagreeing
  // synchronized samples; requests are served only while the CPU is waiting.
  typedef struct {
    bit            is_resume;
    logic [DW-1:0] data;
    int            cyc;
  } event_t;

  event_t        sb[$];
  int            cyc = 0;
  int            proto_errors = 0;
  bit            m_wait_in, m_wait_halt, m_hold;
  logic [DW-1:0] m_in_data, m_out_value;
  int            m_out_count;
  bit            m_s1[2], m_s2[2], m_lvl[2], m_press[2];
  bit            win0[$], win1[$];

  function automatic bit allDiffer(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void keyStep(input int k, input bit pressed);
    bit old;
    old = m_lvl[k];
    if (k == 0) begin
      win0.push_back(m_s2[0]);
      if (win0.size() > DB) void'(win0.pop_front());
      if (allDiffer(win0, old)) begin
        m_lvl[0] = !old;
        win0.delete();
      end
    end else begin
      win1.push_back(m_s2[1]);
      if (win1.size() > DB) void'(win1.pop_front());
      if (allDiffer(win1, old)) begin
        m_lvl[1] = !old;
        win1.delete();
      end
    end
    m_s2[k]    = m_s1[k];
    m_s1[k]    = pressed;
    m_press[k] = m_lvl[k] && !old;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_wait_in   = 1'b0;
      m_wait_halt = 1'b0;
      m_hold      = 1'b0;
      m_in_data   = '0;
      m_out_value = '0;
      m_out_count = 0;
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_lvl[k] = 1'b0; m_press[k] = 1'b0;
      end
      win0.delete();
      win1.delete();
    end else begin
      if (outWrite) begin
        m_out_value = outData;
        m_out_count = (m_out_count + 1) % 256;
      end
      if (m_hold) begin
        if (!m_lvl[0] && !m_lvl[1]) m_hold = 1'b0;
      end else if (m_wait_in) begin
        if (m_press[0]) begin
          m_in_data = DW'(switches);
          sb.push_back('{1'b0, DW'(switches), cyc});
          m_wait_in = 1'b0;
          m_hold    = 1'b1;
        end else if (!inPending) begin
          m_wait_in = 1'b0;
        end
      end else if (m_wait_halt) begin
        if (m_press[1]) begin
          sb.push_back('{1'b1, '0, cyc});
          m_wait_halt = 1'b0;
          m_hold      = 1'b1;
        end else if (!haltPending) begin
          m_wait_halt = 1'b0;
        end
      end else if (inPending) begin
        m_wait_in = 1'b1;
        if (haltPending) begin
          proto_errors++;
          $display("[TB] protocol error: inPending and haltPending both high at cycle %0d", cyc);
        end
      end else if (haltPending) begin
        m_wait_halt = 1'b1;
      end
      keyStep(0, !confirmKey);
      keyStep(1, !resumeKey);
    end
  end

  int in_pulses  = 0;
  int res_pulses = 0;

  always @(negedge clock) begin
    if (inFlag === 1'b1) in_pulses++;
    if (resumeFlag === 1'b1) res_pulses++;
    checkOutput("flags_exclusive", 32'(inFlag & resumeFlag), 32'd0);
    checkOutput("waiting", 32'(waiting), 32'(m_wait_in | m_wait_halt));
    checkOutput("outValue", outValue, m_out_value);
    checkOutput("outCount", 32'(outCount), 32'(m_out_count));
    checkOutput("inData", inData, m_in_data);
  end

  bit     got_resume;
  event_t ev;

  initial begin
    forever begin
      @(negedge clock);
      if (inFlag === 1'b1 || resumeFlag === 1'b1) begin
        got_resume = (resumeFlag === 1'b1);
        @(negedge clock);
        checkOutput("flag_one_cycle", 32'({inFlag, resumeFlag}), 32'd0);
        checkOutput("scoreboard_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          ev = sb.pop_front();
          checkOutput("flag_kind", 32'(got_resume), 32'(ev.is_resume));
          checkOutput("flag_cycle", cyc, ev.cyc);
          if (!got_resume) checkOutput("inData_capture", inData, ev.data);
        end
      end
    end
  end

  int lat, p0, r0, ck_hold, rk_hold;
  bit found;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 1, 1);
    outWrite = 1'b0;
    outData  = '0;
    switches = '0;
    waitCycles(2);
    checkOutput("reset_inFlag", 32'(inFlag), 32'd0);
    checkOutput("reset_resumeFlag", 32'(resumeFlag), 32'd0);
    checkOutput("reset_inData", inData, 32'd0);
    checkOutput("reset_outValue", outValue, 32'd0);
    checkOutput("reset_outCount", 32'(outCount), 32'd0);
    checkOutput("reset_waiting", 32'(waiting), 32'd0);
    reset = 1'b0;

    $display("[TB] basic IN with clean press");
    applyStimulus(1, 0, 1, 1);
    switches = 16'hA5C3;
    waitCycles(3);
    checkOutput("waiting_in", 32'(waiting), 32'd1);
    confirmKey = 1'b0;
    lat = 0;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(negedge clock);
      lat++;
      if (inFlag === 1'b1) found = 1'b1;
    end
    checkOutput("confirm_latency", lat, 32'd6);
    outWrite = 1'b1;
    outData  = 32'hDEADBEEF;
    @(negedge clock);
    outWrite = 1'b0;
    checkOutput("inData_A5C3", inData, 32'h0000A5C3);
    checkOutput("out_with_inflag", outValue, 32'hDEADBEEF);
    checkOutput("waiting_release", 32'(waiting), 32'd0);

    $display("[TB] held key across two IN instructions");
    p0 = in_pulses;
    waitCycles(20);
    checkOutput("held_no_repeat", in_pulses - p0, 32'd0);
    confirmKey = 1'b1;
    waitCycles(10);
    checkOutput("rearmed_wait_in", 32'(waiting), 32'd1);
    p0 = in_pulses;
    confirmKey = 1'b0;
    waitCycles(10);
    checkOutput("second_press_pulse", in_pulses - p0, 32'd1);

    $display("[TB] bouncing key");
    confirmKey = 1'b1;
    waitCycles(12);
    p0 = in_pulses;
    for (int i = 0; i < 10; i++) begin
      confirmKey = ~confirmKey;
      waitCycles(2);
    end
    checkOutput("bounce_no_pulse", in_pulses - p0, 32'd0);
    confirmKey = 1'b0;
    waitCycles(10);
    checkOutput("bounce_then_stable", in_pulses - p0, 32'd1);
    applyStimulus(0, 0, 1, 1);
    waitCycles(12);

    $display("[TB] HALT with resume key");
    applyStimulus(0, 1, 1, 1);
    waitCycles(3);
    checkOutput("waiting_halt", 32'(waiting), 32'd1);
    p0 = in_pulses;
    r0 = res_pulses;
    confirmKey = 1'b0;
    waitCycles(10);
    checkOutput("confirm_in_halt_ignored", in_pulses - p0, 32'd0);
    confirmKey = 1'b1;
    waitCycles(8);
    resumeKey = 1'b0;
    waitCycles(10);
    checkOutput("resume_pulse", res_pulses - r0, 32'd1);
    checkOutput("waiting_after_resume", 32'(waiting), 32'd0);
    applyStimulus(0, 0, 1, 1);
    waitCycles(10);

    $display("[TB] IN and HALT requested together");
    applyStimulus(1, 1, 1, 1);
    waitCycles(2);
    checkOutput("both_waiting", 32'(waiting), 32'd1);
    r0 = res_pulses;
    resumeKey = 1'b0;
    waitCycles(10);
    checkOutput("in_wins_no_resume", res_pulses - r0, 32'd0);
    checkOutput("protocol_error_seen", proto_errors, 32'd1);
    applyStimulus(1, 0, 1, 1);
    waitCycles(8);
    p0 = in_pulses;
    confirmKey = 1'b0;
    waitCycles(10);
    checkOutput("in_after_both", in_pulses - p0, 32'd1);
    applyStimulus(0, 0, 1, 1);
    waitCycles(12);

    $display("[TB] OUT counter wrap");
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      outWrite = 1'b1;
      outData  = 32'(i);
      @(negedge clock);
    end
    outWrite = 1'b0;
    checkOutput("out_wrap_value", outValue, 32'd256);
    checkOutput("out_wrap_count", 32'(outCount), 32'd1);

    $display("[TB] reset during debounce");
    applyStimulus(1, 0, 1, 1);
    waitCycles(3);
    p0 = in_pulses;
    confirmKey = 1'b0;
    waitCycles(5);
    reset = 1'b1;
    confirmKey = 1'b1;
    @(negedge clock);
    checkOutput("midreset_inFlag", 32'(inFlag), 32'd0);
    checkOutput("midreset_inData", inData, 32'd0);
    checkOutput("midreset_outValue", outValue, 32'd0);
    checkOutput("midreset_outCount", 32'(outCount), 32'd0);
    checkOutput("midreset_waiting", 32'(waiting), 32'd0);
    reset = 1'b0;
    waitCycles(12);
    checkOutput("midreset_no_pulse", in_pulses - p0, 32'd0);
    checkOutput("midreset_rewait", 32'(waiting), 32'd1);
    confirmKey = 1'b0;
    waitCycles(10);
    checkOutput("midreset_full_press", in_pulses - p0, 32'd1);
    applyStimulus(0, 0, 1, 1);
    waitCycles(12);

    $display("[TB] random traffic");
    ck_hold = 1;
    rk_hold = 1;
    for (int c = 0; c < 800; c++) begin
      if (!inPending && !haltPending) begin
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 1) inPending = 1'b1;
          else haltPending = 1'b1;
        end
      end else if ($urandom_range(0, 29) == 0) begin
        inPending   = 1'b0;
        haltPending = 1'b0;
      end
      ck_hold--;
      if (ck_hold == 0) begin
        confirmKey = ~confirmKey;
        ck_hold = int'($urandom_range(1, 12));
      end
      rk_hold--;
      if (rk_hold == 0) begin
        resumeKey = ~resumeKey;
        rk_hold = int'($urandom_range(1, 12));
      end
      outWrite = ($urandom_range(0, 3) == 0);
      outData  = $urandom;
      switches = SW'($urandom);
      @(negedge clock);
    end
    applyStimulus(0, 0, 1, 1);
    outWrite = 1'b0;
    waitCycles(20);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/io_handshake_responder.md
Name: io_handshake_responder

Overview:
- Board-side responder for the processor's IN/OUT/HALT stall protocol.
- The control unit stalls the PC while an IN or HALT instruction is pending. This block supplies the matching one-cycle release flags from debounced keys and latches the IN data from switches.
- It also captures OUT data for the display drivers. It sits between the CPU top level and the FPGA board I/O.

Parameters:
DATA_WIDTH, 32, width of inData/outData/outValue
SW_WIDTH, 16, number of switch inputs, zero-extended into inData
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to change a debounced key level (≥2)
KEY_ACTIVE_LOW, 1, 1: raw keys read 0 when pressed

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
inPending  input  1  current instruction is IN (stall requested)
haltPending  input  1  current instruction is HALT
outWrite  input  1  OUT instruction strobe from control unit
outData  input  DATA_WIDTH  value written by OUT
switches  input  SW_WIDTH  raw board switches
confirmKey  input  1  raw key confirming IN data
resumeKey  input  1  raw key releasing HALT
inFlag  output  1  one-cycle pulse: IN data valid (drives control unit "in")
resumeFlag  output  1  one-cycle pulse: leave HALT (drives control unit HALT-exit input)
inData  output  DATA_WIDTH  latched switch value, zero-extended
outValue  output  DATA_WIDTH  last OUT value
outCount  output  8  number of OUT writes, wraps 255->0
waiting  output  1  high in WAIT_IN or WAIT_HALT (board LED)

Behaviour:
- Reset values (sync, checked on clock edge): inFlag=0, resumeFlag=0, inData=0, outValue=0, outCount=0, waiting=0. The FSM goes to IDLE. Synchronizer flops, debounce counters and debounced levels reset to "released".
- Key path, per key:
  - Polarity normalize per KEY_ACTIVE_LOW, then a 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized value equals the debounced level. Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 the debounced level toggles and the counter clears.
  - "press" = one-cycle rising edge of the debounced level.
  - Press latency from a clean raw edge = 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, WAIT_IN, WAIT_HALT, RELEASE.
  - IDLE:
    - inPending=1 -> WAIT_IN.
    - Else haltPending=1 -> WAIT_HALT.
    - If both are high, IN wins. The bench must flag this as a protocol error.
  - WAIT_IN:
    - On confirm press: inData <= {zeros, switches} sampled that cycle, inFlag=1 for exactly that cycle, -> RELEASE.
    - If inPending drops without a press (CPU reset/abort), -> IDLE with no pulse.
  - WAIT_HALT:
    - On resume press: resumeFlag=1 for one cycle, -> RELEASE.
    - If haltPending drops, -> IDLE.
  - RELEASE:
    - Stay until both debounced keys are released, then -> IDLE.
    - This prevents one held press satisfying back-to-back IN instructions.
- Presses arriving in IDLE or RELEASE are discarded, not queued.
- inFlag and resumeFlag are never high simultaneously and never high for more than 1 cycle.
- waiting = (state==WAIT_IN)|(state==WAIT_HALT), registered with the state.
- OUT path is independent of the FSM. When outWrite=1 on a clock edge: outValue <= outData, outCount <= outCount+1 (mod 256). Updates are visible the next cycle. Back-to-back writes each count.
- reset asserted mid-wait or mid-debounce: everything returns to reset values on that edge. The next press must complete a full debounce.

Test Plan:
- DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1. Hold inPending=1, switches=16'hA5C3, drive confirmKey 1->0 and hold. Expect inFlag high exactly 1 cycle, 6 cycles after the edge, inData=32'h0000A5C3, then state RELEASE until the key returns to 1 and is debounced.
- Bounce: toggle confirmKey every 2 cycles for 20 cycles while in WAIT_IN. Expect no inFlag. A stable low then yields exactly one pulse.
- Hold confirmKey pressed across two consecutive IN instructions (inPending stays 1). Expect one inFlag only. The second pulse needs release plus a new press.
- haltPending=1, press resumeKey. Expect one resumeFlag pulse and waiting 1->0. A confirmKey press during WAIT_HALT produces no inFlag.
- outWrite pulsed 257 times with outData=i. Expect outValue=256 and outCount=1 (wrap). outWrite in the same cycle as an inFlag pulse updates both independently.
- Assert reset for 1 cycle during WAIT_IN with a debounce counter at 3. Expect all outputs 0, state IDLE, and no pulse from that press.
